// File: rtl/pipe_stall_sched_if.sv
// Bundle of pipeline-control signals between the stall sequencer and the rest of the core.
// The master side raises hazard and multi-cycle requests; the slave side (sequencer) drives stage modes.
interface pipe_stall_sched_if #(
  parameter int CNT_W = 32
);
  logic [1:0]       hz_if_id_mode;
  logic [1:0]       hz_id_exe_mode;
  logic             hz_if_stall;
  logic             trap_req;
  logic             dmem_req;
  logic             dmem_ready;
  logic             div_req;
  logic             div_done;
  logic             div_start;
  logic             if_stall;
  logic [1:0]       if_id_mode;
  logic [1:0]       id_exe_mode;
  logic [1:0]       exe_mem_mode;
  logic [1:0]       mem_wb_mode;
  logic             wait_err;
  logic [CNT_W-1:0] stall_cnt;

  modport master (
    output hz_if_id_mode, hz_id_exe_mode, hz_if_stall, trap_req,
           dmem_req, dmem_ready, div_req, div_done,
    input  div_start, if_stall, if_id_mode, id_exe_mode, exe_mem_mode,
           mem_wb_mode, wait_err, stall_cnt
  );

  modport slave (
    input  hz_if_id_mode, hz_id_exe_mode, hz_if_stall, trap_req,
           dmem_req, dmem_ready, div_req, div_done,
    output div_start, if_stall, if_id_mode, id_exe_mode, exe_mem_mode,
           mem_wb_mode, wait_err, stall_cnt
  );
endinterface

// File: rtl/pipe_stall_sched.sv
// Central pipeline-control sequencer: merges hazard requests with divider, data-memory and trap
// events, drives per-stage register modes, and guards the wait states with a watchdog.
module pipe_stall_sched #(
  parameter int MAX_WAIT = 64,
  parameter int CNT_W    = 32
) (
  input logic               clk,
  input logic               rst_n,
  pipe_stall_sched_if.slave bus
);

  localparam logic [1:0]       MODE_NORMAL = 2'b00;
  localparam logic [1:0]       MODE_STALL  = 2'b01;
  localparam logic [1:0]       MODE_FLUSH  = 2'b10;
  localparam logic [7:0]       WAIT_LAST   = 8'(MAX_WAIT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

  typedef enum logic [1:0] {RUN, MEM_WAIT, DIV_WAIT} state_e;

  state_e           state, next_state;
  logic [7:0]       wait_cnt;
  logic             wait_err;
  logic [CNT_W-1:0] stall_cnt;

  logic       pat_flush, pat_mem, pat_div, pat_pass;
  logic       start_c, done_c, wd_fire, stall_c;
  logic [1:0] m_if_id, m_id_exe, m_exe_mem, m_mem_wb;

  // NOTE: every signal assigned in an always_comb gets a default first so no path leaves it
  // unassigned; a missed branch would otherwise infer a latch.
  always_comb begin
    next_state = state;
    pat_flush  = 1'b0;
    pat_mem    = 1'b0;
    pat_div    = 1'b0;
    pat_pass   = 1'b0;
    start_c    = 1'b0;
    done_c     = 1'b0;
    wd_fire    = 1'b0;

    unique case (state)
      RUN: begin
        if (bus.trap_req) begin
          pat_flush = 1'b1;
        end else if (bus.dmem_req && !bus.dmem_ready) begin
          pat_mem    = 1'b1;
          next_state = MEM_WAIT;
        end else if (bus.div_req) begin
          pat_div    = 1'b1;
          start_c    = 1'b1;
          next_state = DIV_WAIT;
        end else begin
          pat_pass = 1'b1;
        end
      end
      MEM_WAIT, DIV_WAIT: begin
        done_c = (state == MEM_WAIT) ? bus.dmem_ready : bus.div_done;
        // Completion beats the watchdog when both land in the same cycle.
        if (done_c) begin
          next_state = RUN;
        end else if (wait_cnt == WAIT_LAST) begin
          pat_flush  = 1'b1;
          wd_fire    = 1'b1;
          next_state = RUN;
        end else begin
          pat_mem = (state == MEM_WAIT);
          pat_div = (state == DIV_WAIT);
        end
      end
      default: next_state = RUN;
    endcase

    stall_c   = pat_mem | pat_div | (pat_pass & bus.hz_if_stall);
    m_if_id   = MODE_NORMAL;
    m_id_exe  = MODE_NORMAL;
    m_exe_mem = MODE_NORMAL;
    m_mem_wb  = MODE_NORMAL;
    if (pat_flush) begin
      m_if_id   = MODE_FLUSH;
      m_id_exe  = MODE_FLUSH;
      m_exe_mem = MODE_FLUSH;
      m_mem_wb  = MODE_FLUSH;
    end else if (pat_mem) begin
      m_if_id   = MODE_STALL;
      m_id_exe  = MODE_STALL;
      m_exe_mem = MODE_STALL;
      m_mem_wb  = MODE_FLUSH;
    end else if (pat_div) begin
      m_if_id   = MODE_STALL;
      m_id_exe  = MODE_STALL;
      m_exe_mem = MODE_FLUSH;
    end else if (pat_pass) begin
      m_if_id   = bus.hz_if_id_mode;
      m_id_exe  = bus.hz_id_exe_mode;
    end
  end

  // Outputs are forced quiet while reset is held, independent of the current state.
  assign bus.div_start    = rst_n & start_c;
  assign bus.if_stall     = rst_n & stall_c;
  assign bus.if_id_mode   = rst_n ? m_if_id   : MODE_NORMAL;
  assign bus.id_exe_mode  = rst_n ? m_id_exe  : MODE_NORMAL;
  assign bus.exe_mem_mode = rst_n ? m_exe_mem : MODE_NORMAL;
  assign bus.mem_wb_mode  = rst_n ? m_mem_wb  : MODE_NORMAL;
  assign bus.wait_err     = wait_err;
  assign bus.stall_cnt    = stall_cnt;

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= RUN;
      wait_cnt  <= '0;
      wait_err  <= 1'b0;
      stall_cnt <= '0;
    end else begin
      state <= next_state;
      // Held at zero in RUN so each wait state starts counting from zero.
      if (state == RUN) begin
        wait_cnt <= '0;
      end else if (!done_c && !wd_fire) begin
        wait_cnt <= wait_cnt + 8'd1;
      end
      if (wd_fire) begin
        wait_err <= 1'b1;
      end
      if (stall_c && (stall_cnt != '1)) begin
        stall_cnt <= stall_cnt + CNT_ONE;
      end
    end
  end

endmodule

// File: tb/tb_pipe_stall_sched.sv
// Scoreboard bench for pipe_stall_sched: a driver pushes model predictions per cycle, a monitor
// pops and compares them against the DUT outputs on the falling edge.
module tb_pipe_stall_sched;

  localparam int MAX_WAIT = 40;
  localparam int CNT_W    = 6;
  localparam int CNT_MAX  = (1 << CNT_W) - 1;

  localparam logic [1:0] N = 2'b00;
  localparam logic [1:0] S = 2'b01;
  localparam logic [1:0] F = 2'b10;

  typedef enum int {P_NORM, P_PASS, P_MEM, P_DIV, P_FLUSH} pat_e;

  typedef struct packed {
    logic             div_start;
    logic             if_stall;
    logic [1:0]       if_id;
    logic [1:0]       id_exe;
    logic [1:0]       exe_mem;
    logic [1:0]       mem_wb;
    logic             wait_err;
    logic [CNT_W-1:0] stall_cnt;
  } obs_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  pipe_stall_sched_if #(.CNT_W(CNT_W)) bus ();

  pipe_stall_sched #(.MAX_WAIT(MAX_WAIT), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  obs_t exp_q[$];
  int   n_vec = 0;
  int   n_bad = 0;

  // Reference model: which kind of wait is pending (0 none, 1 memory, 2 divide), how many
  // wait cycles have elapsed, the sticky error and the total stall count.
  int m_phase, m_waited, m_stalls;
  bit m_err;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  function automatic obs_t sample();
    obs_t o;
    o.div_start = bus.div_start;
    o.if_stall  = bus.if_stall;
    o.if_id     = bus.if_id_mode;
    o.id_exe    = bus.id_exe_mode;
    o.exe_mem   = bus.exe_mem_mode;
    o.mem_wb    = bus.mem_wb_mode;
    o.wait_err  = bus.wait_err;
    o.stall_cnt = bus.stall_cnt;
    return o;
  endfunction

  task automatic set_inputs(input logic [1:0] hii, input logic [1:0] hie, input logic hs,
                            input logic tr, input logic dq, input logic dr,
                            input logic vq, input logic vd);
    bus.hz_if_id_mode  = hii;
    bus.hz_id_exe_mode = hie;
    bus.hz_if_stall    = hs;
    bus.trap_req       = tr;
    bus.dmem_req       = dq;
    bus.dmem_ready     = dr;
    bus.div_req        = vq;
    bus.div_done       = vd;
  endtask

  task automatic model_reset();
    m_phase  = 0;
    m_waited = 0;
    m_stalls = 0;
    m_err    = 1'b0;
  endtask

  // Apply one cycle of stimulus just after the rising edge and queue the predicted response.
  task automatic drive(input logic [1:0] hii, input logic [1:0] hie, input logic hs,
                       input logic tr, input logic dq, input logic dr,
                       input logic vq, input logic vd);
    obs_t e;
    pat_e pat;
    bit   done;
    @(posedge clk);
    #1;
    set_inputs(hii, hie, hs, tr, dq, dr, vq, vd);
    e           = '0;
    e.wait_err  = m_err;
    e.stall_cnt = CNT_W'(m_stalls);
    if (m_phase == 0) begin
      if (tr) begin
        pat = P_FLUSH;
      end else if (dq && !dr) begin
        pat = P_MEM; m_phase = 1; m_waited = 0;
      end else if (vq) begin
        pat = P_DIV; e.div_start = 1'b1; m_phase = 2; m_waited = 0;
      end else begin
        pat = P_PASS;
      end
    end else begin
      done = (m_phase == 1) ? dr : vd;
      if (done) begin
        pat = P_NORM; m_phase = 0;
      end else if (m_waited == MAX_WAIT - 1) begin
        pat = P_FLUSH; m_err = 1'b1; m_phase = 0;
      end else begin
        pat = (m_phase == 1) ? P_MEM : P_DIV;
        m_waited++;
      end
    end
    case (pat)
      P_FLUSH: {e.if_id, e.id_exe, e.exe_mem, e.mem_wb} = {F, F, F, F};
      P_MEM:   begin {e.if_id, e.id_exe, e.exe_mem, e.mem_wb} = {S, S, S, F}; e.if_stall = 1'b1; end
      P_DIV:   begin {e.if_id, e.id_exe, e.exe_mem, e.mem_wb} = {S, S, F, N}; e.if_stall = 1'b1; end
      P_PASS:  begin {e.if_id, e.id_exe, e.exe_mem, e.mem_wb} = {hii, hie, N, N}; e.if_stall = hs; end
      default: {e.if_id, e.id_exe, e.exe_mem, e.mem_wb} = {N, N, N, N};
    endcase
    if (e.if_stall) m_stalls = (m_stalls < CNT_MAX) ? m_stalls + 1 : CNT_MAX;
    exp_q.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(N, N, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  // Monitor: the DUT presents a full output word every cycle; compare it on the falling edge.
  initial begin
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        obs_t e;
        e = exp_q.pop_front();
        check("cycle_outputs", sample(), e);
      end
    end
  end

  initial begin
    model_reset();
    // Reset held with active requests: every output must stay quiet.
    set_inputs(S, F, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    #3;
    check("reset_state", sample(), obs_t'('0));
    set_inputs(N, N, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    // Load-use pass-through and other hazard patterns.
    drive(S, F, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    drive(F, S, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    drive(S, S, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Zero-wait memory access, then a three-cycle stall followed by ready.
    drive(N, N, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) drive(S, F, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    drive(S, F, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    idle(1);

    // 33-cycle divide, then a back-to-back divide launched the cycle after done.
    drive(N, N, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 32; i++) drive(S, S, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    drive(N, N, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    drive(N, N, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) drive(N, N, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    drive(N, N, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

    // Priority: trap beats memory wait and divide.
    drive(S, F, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    idle(1);

    // Watchdog race: completion on the final allowed wait cycle exits normally.
    drive(N, N, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < MAX_WAIT - 1; i++) drive(N, N, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    drive(N, N, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    idle(2);

    // Watchdog expiry: ready never arrives.
    drive(N, N, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < MAX_WAIT; i++) drive(N, N, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    idle(2);

    // Asynchronous reset in the middle of a divide wait.
    drive(N, N, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) drive(N, N, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    @(posedge clk);
    #2;
    set_inputs(S, S, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    rst_n = 1'b0;
    #1;
    check("async_reset_mid_div", sample(), obs_t'('0));
    set_inputs(N, N, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    drive(S, F, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      drive(2'($urandom_range(0, 2)), 2'($urandom_range(0, 2)), 1'($urandom),
            1'($urandom % 10 == 0), 1'($urandom % 3 == 0), 1'($urandom),
            1'($urandom % 4 == 0), 1'($urandom % 12 == 0));
    end

    @(negedge clk);
    @(negedge clk);
    check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
